// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: drives one external full-adder cell LSB first
// over WIDTH cycles and registers the WIDTH-bit sum plus carry-out.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_s,
    input  logic             fa_carry
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
    logic [WIDTH-1:0] sum_nx;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             last_bit;

    assign sum_nx   = {fa_s, sum_sh[WIDTH-1:1]};
    assign last_bit = (cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            Sum     <= '0;
            Cout    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh    <= A;
                        b_sh    <= B;
                        carry_q <= Cin;
                        cnt     <= '0;
                    end
                end
                S_RUN: begin
                    sum_sh  <= sum_nx;
                    carry_q <= fa_carry;
                    a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
                    // Explicit wrap: WIDTH need not be a power of two
                    if (last_bit) begin
                        Sum  <= sum_nx;
                        Cout <= fa_carry;
                        cnt  <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        fa_a     = 1'b0;
        fa_b     = 1'b0;
        fa_c     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                fa_a = a_sh[0];
                fa_b = b_sh[0];
                fa_c = carry_q;
                if (last_bit) state_nx = S_DONE;
            end
            S_DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule
